// File: rtl/button_press_counter.sv
// Purpose: synchronize and debounce a raw push-button level, count accepted presses on a wrapping LED register.
// Latency: press/leds update DB_CYCLES+2 edges after the first edge that samples btn_in=1 (2-flop sync plus debounce).
// Backpressure: none; press is a fire-and-forget one-cycle pulse, and clr is a synchronous clear of leds only.
module button_press_counter #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int DB_W      = 20,
    parameter int LED_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    input  logic             clr,
    output logic             press,
    output logic             pressed,
    output logic [LED_W-1:0] leds
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic            s1;
    logic            btn_s;
    state_t          state;
    state_t          state_nxt;
    logic [DB_W-1:0] cnt;
    logic [DB_W-1:0] cnt_nxt;
    logic            press_nxt;
    logic            pressed_nxt;
    logic            inc;

    // btn_in is asynchronous; only btn_s may be used past this point
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            s1    <= btn_in;
            btn_s <= s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            press   <= 1'b0;
            pressed <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            press   <= press_nxt;
            pressed <= pressed_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        inc       = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                    inc       = 1'b1;
                end else begin
                    cnt_nxt = cnt + DB_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                // a bounce back high returns to PRESSED without a new pulse
                if (btn_s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + DB_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        pressed_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
    end

    // clr wins over a same-edge increment; the counter wraps silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds <= '0;
        end else if (clr) begin
            leds <= '0;
        end else if (inc) begin
            leds <= leds + LED_W'(1);
        end
    end

endmodule

// File: tb/tb_button_press_counter.sv
// Self-checking bench for button_press_counter with DB_CYCLES=4; a negedge monitor
// pops the expected leds value from a scoreboard queue on every press pulse.
module tb_button_press_counter;

    localparam int DB_CYCLES = 4;
    localparam int DB_W      = 20;
    localparam int LED_W     = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             btn_in;
    logic             clr;
    logic             press;
    logic             pressed;
    logic [LED_W-1:0] leds;

    int               errors = 0;
    int               checks = 0;
    int               pulses = 0;
    logic [LED_W-1:0] sb_q[$];
    logic [LED_W-1:0] exp_leds;

    button_press_counter #(
        .DB_CYCLES(DB_CYCLES),
        .DB_W     (DB_W),
        .LED_W    (LED_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_in),
        .clr    (clr),
        .press  (press),
        .pressed(pressed),
        .leds   (leds)
    );

    always #5 clk = ~clk;

    // scoreboard consumer: every press pulse must match a queued expectation
    always @(negedge clk) begin
        if (!rst && press === 1'b1) begin
            pulses = pulses + 1;
            checks = checks + 1;
            if (sb_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL sb_unexpected_pulse: leds=%0d, no pulse expected", leds);
            end else begin
                exp_leds = sb_q.pop_front();
                if (leds !== exp_leds) begin
                    errors = errors + 1;
                    $display("FAIL sb_leds: got %0d, expected %0d", leds, exp_leds);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        btn_in = 1'b0;
        clr    = 1'b0;
        step(2);
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic check_sb_empty(input string name);
        checks = checks + 1;
        if (sb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL %s_sb_pending: %0d pulses missing, expected 0", name, sb_q.size());
        end
    endtask

    // press with full timing checks; expected leds value is pushed up front
    task automatic checked_press(input logic [LED_W-1:0] exp);
        btn_in = 1'b1;
        sb_q.push_back(exp);
        step(DB_CYCLES + 2);
        checks = checks + 1;
        if (press !== 1'b0 || pressed !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL press_early: press=%b pressed=%b, expected 0/0", press, pressed);
        end
        step(1);
        checks = checks + 1;
        if (press !== 1'b1 || pressed !== 1'b1 || leds !== exp) begin
            errors = errors + 1;
            $display("FAIL press_edge: press=%b pressed=%b leds=%0d, expected 1/1/%0d",
                     press, pressed, leds, exp);
        end
        step(1);
        checks = checks + 1;
        if (press !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL press_width: press=%b, expected 0", press);
        end
    endtask

    task automatic checked_release();
        btn_in = 1'b0;
        step(DB_CYCLES + 2);
        checks = checks + 1;
        if (pressed !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL release_early: pressed=%b, expected 1", pressed);
        end
        step(1);
        checks = checks + 1;
        if (pressed !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL release_edge: pressed=%b, expected 0", pressed);
        end
    endtask

    task automatic fast_press(input logic [LED_W-1:0] exp);
        btn_in = 1'b1;
        sb_q.push_back(exp);
        step(DB_CYCLES + 4);
        btn_in = 1'b0;
        step(DB_CYCLES + 4);
    endtask

    task automatic test_reset();
        apply_reset();
        checks = checks + 1;
        if (press !== 1'b0 || pressed !== 1'b0 || leds !== '0) begin
            errors = errors + 1;
            $display("FAIL reset_state: press=%b pressed=%b leds=%0d, expected 0/0/0",
                     press, pressed, leds);
        end
        checked_press(8'd1);
        step(1);
        // asynchronous assert mid-cycle with the button still held
        #3;
        rst = 1'b1;
        #1;
        checks = checks + 1;
        if (press !== 1'b0 || pressed !== 1'b0 || leds !== '0) begin
            errors = errors + 1;
            $display("FAIL reset_async: press=%b pressed=%b leds=%0d, expected 0/0/0",
                     press, pressed, leds);
        end
        step(2);
        rst = 1'b0;
        sb_q.push_back(8'd1);
        step(DB_CYCLES + 2);
        checks = checks + 1;
        if (press !== 1'b0 || leds !== '0) begin
            errors = errors + 1;
            $display("FAIL reset_held_early: press=%b leds=%0d, expected 0/0", press, leds);
        end
        step(1);
        checks = checks + 1;
        if (press !== 1'b1 || leds !== 8'd1) begin
            errors = errors + 1;
            $display("FAIL reset_held_press: press=%b leds=%0d, expected 1/1", press, leds);
        end
        step(1);
        checked_release();
        check_sb_empty("reset");
    endtask

    task automatic test_clean_press();
        apply_reset();
        checked_press(8'd1);
        step(14);
        checked_release();
        check_sb_empty("clean");
    endtask

    task automatic test_bounce();
        int p0;
        apply_reset();
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            btn_in = 1'b1;
            step(3);
            btn_in = 1'b0;
            step(2);
        end
        btn_in = 1'b1;
        sb_q.push_back(8'd1);
        step(20);
        // release with short highs landing inside RELEASE_WAIT
        for (int i = 0; i < 3; i++) begin
            btn_in = 1'b0;
            step(2);
            btn_in = 1'b1;
            step(2);
        end
        btn_in = 1'b0;
        step(20);
        checks = checks + 1;
        if (pulses - p0 != 1 || leds !== 8'd1 || pressed !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL bounce: pulses=%0d leds=%0d pressed=%b, expected 1/1/0",
                     pulses - p0, leds, pressed);
        end
        check_sb_empty("bounce");
    endtask

    task automatic test_wrap();
        int p0;
        apply_reset();
        p0 = pulses;
        for (int i = 0; i < 256; i++) begin
            fast_press(LED_W'(i + 1));
        end
        checks = checks + 1;
        if (pulses - p0 != 256 || leds !== 8'd0) begin
            errors = errors + 1;
            $display("FAIL wrap: pulses=%0d leds=%0d, expected 256/0", pulses - p0, leds);
        end
        check_sb_empty("wrap");
    endtask

    task automatic test_clr_collision();
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            fast_press(LED_W'(i));
        end
        btn_in = 1'b1;
        sb_q.push_back(8'd0);
        step(DB_CYCLES + 2);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        checks = checks + 1;
        if (press !== 1'b1 || leds !== 8'd0) begin
            errors = errors + 1;
            $display("FAIL clr_collision: press=%b leds=%0d, expected 1/0", press, leds);
        end
        step(2);
        checked_release();
        checked_press(8'd1);
        checked_release();
        check_sb_empty("clr");
    endtask

    task automatic test_back_to_back();
        int   p0;
        logic dropped;
        apply_reset();
        p0 = pulses;
        checked_press(8'd1);
        btn_in = 1'b0;
        dropped = 1'b0;
        step(2);
        btn_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (pressed !== 1'b1) dropped = 1'b1;
        end
        checks = checks + 1;
        if (dropped !== 1'b0 || pulses - p0 != 1 || leds !== 8'd1) begin
            errors = errors + 1;
            $display("FAIL repress: dropped=%b pulses=%0d leds=%0d, expected 0/1/1",
                     dropped, pulses - p0, leds);
        end
        checked_release();
        check_sb_empty("repress");
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 1'b0;
        clr    = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_wrap();
        test_clr_collision();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
